// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind uart_rx with first-word-fall-through read port.
// Optional UART_RX_FIFO_STATS_EN adds accepted/dropped byte counters.
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overrun,
`ifdef UART_RX_FIFO_STATS_EN
  output logic [15:0]       rx_byte_cnt,
  output logic [15:0]       drop_cnt,
`endif
  input  logic              clr_overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT =
    {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              overrun_q, overrun_d;
  logic              rx_done_d_q;

  logic              wr_evt;
  logic              wr_en;
  logic              rd_en;
  logic              drop;

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0]       rx_byte_cnt_q, rx_byte_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

  // Occupancy and status flags derived from the extended pointers.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    rd_valid = ~empty;
    rd_data  = rd_data_q;
    overrun  = overrun_q;
  end

  // Event decode, pointer/flag next state and next head byte.
  always_comb begin
    wr_evt    = rx_done & ~rx_done_d_q;
    rd_en     = rd_valid & rd_ready;
    wr_en     = wr_evt & (~full | rd_en);
    drop      = wr_evt & full & ~rd_en;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    overrun_d = overrun_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Head only changes on a push or pop; a write landing on the
    // new head slot is bypassed since the RAM still holds old data.
    if (wr_en || rd_en) begin
      if (wr_en &&
          (wr_ptr_q[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0])) begin
        rd_data_d = rx_data;
      end else begin
        rd_data_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
      end
    end
    // A new drop beats a clear in the same cycle.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  // Free-running statistics counters, wrapping naturally.
  always_comb begin
    rx_byte_cnt_d = rx_byte_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    if (wr_en) begin
      rx_byte_cnt_d = rx_byte_cnt_q + 16'd1;
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
    rx_byte_cnt = rx_byte_cnt_q;
    drop_cnt    = drop_cnt_q;
  end
`endif

  // Edge-detect history follows rx_done even in reset so a strobe
  // held across reset release is not seen as a new byte.
  always_ff @(posedge clk) begin
    rx_done_d_q <= rx_done;
  end

  // Pointer, head-data and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_byte_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      rx_byte_cnt_q <= rx_byte_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end
`endif

  // Storage array; contents are never reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Define UART_RX_FIFO_STATS_EN to also check the counters.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overrun;
  logic       clr_overrun;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] rx_byte_cnt;
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overrun     (overrun),
`ifdef UART_RX_FIFO_STATS_EN
    .rx_byte_cnt (rx_byte_cnt),
    .drop_cnt    (drop_cnt),
`endif
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_data     = '0;
    rx_done     = 1'b0;
    rd_ready    = 1'b0;
    clr_overrun = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_data", rd_data, 0);

    // single byte, FWFT latency
    rx_data = 8'hAB;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("t1_valid", rd_valid, 1);
    chk("t1_data", rd_data, 8'hAB);
    chk("t1_count", count, 1);
    pop();
    chk("t1_empty", empty, 1);
    chk("t1_count0", count, 0);

    // long rx_done counts once
    rx_data = 8'h5A;
    rx_done = 1'b1;
    tick();
    tick();
    tick();
    rx_done = 1'b0;
    tick();
    chk("t2_count", count, 1);
    chk("t2_data", rd_data, 8'h5A);
    pop();
    chk("t2_empty", empty, 1);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    chk("t3_full", full, 1);
    chk("t3_count", count, 16);
    chk("t3_ovr0", overrun, 0);
    wr_byte(8'hFF);
    chk("t3_ovr1", overrun, 1);
    chk("t3_cnt_drop", count, 16);
`ifdef UART_RX_FIFO_STATS_EN
    chk("t3_rxcnt", rx_byte_cnt, 18);
    chk("t3_dropcnt", drop_cnt, 1);
`endif
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_d%0d", i), rd_data, 8'(i));
      pop();
    end
    chk("t3_empty", empty, 1);
    chk("t3_ovr_held", overrun, 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("t5_clr", overrun, 0);

    // clear and drop in the same cycle: set wins
    for (int i = 0; i < 16; i++) wr_byte(8'h20 + 8'(i));
    rx_data     = 8'hEE;
    rx_done     = 1'b1;
    clr_overrun = 1'b1;
    tick();
    rx_done     = 1'b0;
    clr_overrun = 1'b0;
    chk("setwins_ovr", overrun, 1);
    tick();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("setwins_clr", overrun, 0);

    // full with simultaneous write and pop
    rx_data  = 8'h77;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    tick();
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    chk("t4_count", count, 16);
    chk("t4_ovr", overrun, 0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("t4_d%0d", i), rd_data, 8'h20 + 8'(i));
      pop();
    end
    chk("t4_last", rd_data, 8'h77);
    pop();
    chk("t4_empty", empty, 1);

    // mid-occupancy write + pop keeps count
    wr_byte(8'h11);
    rx_data  = 8'h22;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    tick();
    rx_done  = 1'b0;
    rd_ready = 1'b0;
    chk("mid_count", count, 1);
    chk("mid_data", rd_data, 8'h22);
    pop();

    // streaming with rd_ready held high
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'(i * 3 + 1);
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      chk($sformatf("t5_v%0d", i), rd_valid, 1);
      chk($sformatf("t5_d%0d", i), rd_data, 8'(i * 3 + 1));
      chk($sformatf("t5_c%0d", i), count, 1);
      tick();
      chk($sformatf("t5_e%0d", i), empty, 1);
    end
    rd_ready = 1'b0;

    // reset mid-stream with rx_done held through it
    for (int i = 0; i < 5; i++) wr_byte(8'h40 + 8'(i));
    chk("t6_count5", count, 5);
    rx_data = 8'h99;
    rx_done = 1'b1;
    rst_n   = 1'b0;
    tick();
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_valid", rd_valid, 0);
`ifdef UART_RX_FIFO_STATS_EN
    chk("t6_rxcnt", rx_byte_cnt, 0);
    chk("t6_dropcnt", drop_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_nocount", count, 0);
    rx_done = 1'b0;
    tick();
    wr_byte(8'h3C);
    chk("t6_after", rd_data, 8'h3C);
    chk("t6_after_c", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
